// File: rtl/gate_in_pkg.sv
// Shared state encoding and default debounce length for the gate input front ends.
package gate_in_pkg;

   localparam int DEFAULT_STABLE_CYCLES = 4;

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_HIGH      = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } state_t;

endpackage

// File: rtl/gate_input_debouncer_sync_2ff.sv
// Two-flop synchroniser for a raw asynchronous bit; reusable by any gate front end.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/gate_input_debouncer.sv
// Synchronised stable-count debouncer with one-cycle rise/fall pulses.
// Optional macro OUT_INVERT_EN presents y as the inverted debounced level.
module gate_input_debouncer
   import gate_in_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic y,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             aSync;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (a),
      .q   (aSync)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Any sample that disagrees with the pending level drops back to the settled state.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (aSync) begin
               state_d = ST_WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         ST_WAIT_HIGH: begin
            if (!aSync) begin
               state_d = ST_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               lvl_d   = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!aSync) begin
               state_d = ST_WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         ST_WAIT_LOW: begin
            if (aSync) begin
               state_d = ST_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               lvl_d   = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = ST_LOW;
      endcase
   end

`ifdef OUT_INVERT_EN
   assign y = ~lvl_q;
`else
   assign y = lvl_q;
`endif
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Self-checking bench: table-driven vectors plus hand sequences, scoreboarded against a run-length model.
`timescale 1ns/1ps
module tb_gate_input_debouncer;

   localparam int STABLE = 4;

   typedef struct {
      bit a;
      bit rst;
      int hold;
   } vec_t;

   typedef struct {
      bit    y;
      bit    rise;
      bit    fall;
      string tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a   = 1'b0;
   logic y, rise, fall;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   riseSeen = 0;
   int   fallSeen = 0;

   bit mS1 = 0, mS2 = 0, mLvl = 0, mRise = 0, mFall = 0;
   int mRun = 0;

   gate_input_debouncer #(.STABLE_CYCLES(STABLE)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .y    (y),
      .rise (rise),
      .fall (fall)
   );

   always #5 clk = ~clk;

   // Reference: level flips once STABLE consecutive synchronised samples disagree with it.
   task automatic modelEdge(input bit aVal, input bit rstVal);
      if (rstVal) begin
         mS1 = 0; mS2 = 0; mLvl = 0; mRun = 0; mRise = 0; mFall = 0;
      end else begin
         mRise = 0;
         mFall = 0;
         if (mS2 != mLvl) begin
            mRun++;
            if (mRun == STABLE) begin
               mLvl  = mS2;
               mRise = mS2;
               mFall = !mS2;
               mRun  = 0;
            end
         end else begin
            mRun = 0;
         end
         mS2 = mS1;
         mS1 = aVal;
      end
   endtask

   task automatic check(input string name, input logic act, input bit req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard: queue empty at %0t", $time);
         return;
      end
      e = expQ.pop_front();
      check({e.tag, ".y"}, y, e.y);
      check({e.tag, ".rise"}, rise, e.rise);
      check({e.tag, ".fall"}, fall, e.fall);
      if (rise === 1'b1) riseSeen++;
      if (fall === 1'b1) fallSeen++;
   endtask

   task automatic applyStimulus(input bit aVal, input bit rstVal, input string tag);
      exp_t e;
      a   = aVal;
      rst = rstVal;
      @(posedge clk);
      modelEdge(aVal, rstVal);
`ifdef OUT_INVERT_EN
      e.y = !mLvl;
`else
      e.y = mLvl;
`endif
      e.rise = mRise;
      e.fall = mFall;
      e.tag  = tag;
      expQ.push_back(e);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic hold(input bit aVal, input bit rstVal, input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(aVal, rstVal, tag);
   endtask

   initial begin
      vec_t vectors[6];
      int   r0, f0;
      vectors[0] = '{a: 1, rst: 1, hold: 3};
      vectors[1] = '{a: 1, rst: 0, hold: 8};
      vectors[2] = '{a: 0, rst: 0, hold: 8};
      vectors[3] = '{a: 1, rst: 0, hold: 5};
      vectors[4] = '{a: 1, rst: 0, hold: 3};
      vectors[5] = '{a: 0, rst: 0, hold: 8};

      @(negedge clk);
      for (int v = 0; v < 6; v++) hold(vectors[v].a, vectors[v].rst, vectors[v].hold, $sformatf("vec%0d", v));

      // Reset then exactly six edges to the rising level.
      hold(1, 1, 3, "rstA1");
      r0 = riseSeen;
      hold(1, 0, 5, "rel");
      check("latency.y_before_6th", y, `ifdef OUT_INVERT_EN 1'b1 `else 1'b0 `endif);
      applyStimulus(1, 0, "edge6");
      check("latency.rise_at_6th", rise, 1'b1);
      hold(1, 0, 3, "settleH");
      check("latency.one_rise", 1'(riseSeen - r0 == 1), 1'b1);
      hold(0, 0, 8, "settleL");

      // Bouncing every two cycles never settles.
      r0 = riseSeen;
      f0 = fallSeen;
      for (int i = 0; i < 5; i++) begin
         hold(1, 0, 2, "bounceH");
         hold(0, 0, 2, "bounceL");
      end
      hold(0, 0, 4, "bounceEnd");
      check("bounce.no_rise", 1'(riseSeen == r0), 1'b1);
      check("bounce.no_fall", 1'(fallSeen == f0), 1'b1);

      // Three samples high is one short; four is enough.
      r0 = riseSeen;
      hold(1, 0, 3, "glitch3");
      hold(0, 0, 8, "glitch3L");
      check("glitch3.no_rise", 1'(riseSeen == r0), 1'b1);
      hold(1, 0, 4, "glitch4");
      hold(0, 0, 1, "glitch4L");
      hold(0, 0, 5, "glitch4W");
      check("glitch4.one_rise", 1'(riseSeen - r0 == 1), 1'b1);
      hold(1, 0, 8, "glitch4Hold");

      // Reset in the middle of the low count must not emit a fall.
      f0 = fallSeen;
      hold(0, 0, 4, "waitLow");
      hold(0, 1, 1, "rstMid");
      hold(0, 0, 8, "afterRst");
      check("rstMid.no_fall", 1'(fallSeen == f0), 1'b1);
      hold(1, 0, 8, "restartH");

      // Input returns on the terminal count sample: no fall.
      f0 = fallSeen;
      hold(0, 0, 3, "abortL");
      hold(1, 0, 8, "abortH");
      check("abort.no_fall", 1'(fallSeen == f0), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: bench did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule
